// File: rtl/uart_rx_byte_receiver.sv
// uart_rx_byte_receiver: 8N1 serial receiver with valid/ready holding register, framing and overrun flags
module uart_rx_byte_receiver #(
  parameter int clk_mhz   = 25,
  parameter int baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overrun
);
  localparam int bit_cycles  = clk_mhz * 1_000_000 / baud_rate;
  localparam int half_cycles = bit_cycles / 2;
  localparam int cw          = $clog2(bit_cycles);
  localparam logic [cw-1:0] bit_last  = cw'(bit_cycles - 1);
  localparam logic [cw-1:0] half_last = cw'(half_cycles - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic s1_q, s1_d, s2_q, s2_d;
  logic deliver_q, deliver_d, rx_valid_q, rx_valid_d;
  logic framing_error_q, framing_error_d, overrun_q, overrun_d;
  logic rx_s, load;
  assign rx_s          = s2_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  // Frame FSM with mid-bit sampling, synchronizer and holding-register handshake
  always_comb begin
    s1_d = uart_rx;
    s2_d = s1_q;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d = shift_q;
    deliver_d = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == half_last) begin
        cnt_d = '0;
        bit_idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == bit_last) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        state_d = (bit_idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == bit_last) begin
        cnt_d = '0;
        deliver_d = rx_s;
        framing_error_d = ~rx_s;
        state_d = rx_s ? IDLE : BRK;
      end
      BRK: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : BRK;
      end
      default: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
    load = deliver_q & (~rx_valid_q | rx_ready);
    rx_data_d = load ? shift_q : rx_data_q;
    rx_valid_d = load | (rx_valid_q & ~rx_ready);
    overrun_d = overrun_q | (deliver_q & ~load);
  end
  // State registers; synchronizer resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q <= '0;
      deliver_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q <= shift_d;
      deliver_q <= deliver_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
